// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter: rotate / logical / arithmetic shifter, one pipeline
// stage per shift-amount bit (LSB first), single global advance enable.
module pipelined_barrel_shifter #(
    parameter int WIDTH       = 16,
    parameter int SHAMT_WIDTH = $clog2(WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       a_in,
    input  logic [SHAMT_WIDTH-1:0] shamt,
    input  logic                   dir,
    input  logic [1:0]             mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       a_out
);
    localparam int L = SHAMT_WIDTH;

    // One fixed-distance step; s is always a power of two below WIDTH.
    // Mode 11 falls into the logical branch on purpose.
    function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] d,
                                                    input int s,
                                                    input logic right,
                                                    input logic [1:0] md);
        logic [WIDTH-1:0]        r;
        logic signed [WIDTH-1:0] sd;
        sd = d;
        case (md)
            2'b00:   r = right ? ((d >> s) | (d << (WIDTH - s)))
                               : ((d << s) | (d >> (WIDTH - s)));
            2'b10: begin
                // kept as its own statement so the signed operand is not
                // demoted to unsigned by a mixed conditional expression
                if (right) r = sd >>> s;
                else       r = d << s;
            end
            default: r = right ? (d >> s) : (d << s);
        endcase
        return r;
    endfunction

    logic         adv;
    logic [L-1:0] vld_d, vld_q;

    assign out_valid = vld_q[L-1];
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;

    // valid shift register: new beat (or bubble) enters stage 0, all move on adv
    always_comb begin
        vld_d = vld_q;
        if (adv) vld_d = {vld_q[L-2:0], in_valid};
    end

    // valid bits clear on reset so in-flight beats are discarded
    always_ff @(posedge clk) begin
        if (rst) vld_q <= '0;
        else     vld_q <= vld_d;
    end

    // Stage k register holds data with shifts 2^0..2^(k-1) already applied,
    // plus only the shamt bits not yet consumed; the 2^k step follows it.
    for (genvar k = 0; k < L; k++) begin : g_st
        logic [WIDTH-1:0] dat_d, dat_q, res, up_dat;
        logic [L-1-k:0]   sh_d, sh_q, up_sh;
        logic             dir_d, dir_q, up_dir;
        logic [1:0]       mode_d, mode_q, up_mode;

        if (k == 0) begin : g_src
            assign up_dat  = a_in;
            assign up_sh   = shamt;
            assign up_dir  = dir;
            assign up_mode = mode;
        end else begin : g_src
            assign up_dat  = g_st[k-1].res;
            assign up_sh   = g_st[k-1].sh_q[L-k:1];
            assign up_dir  = g_st[k-1].dir_q;
            assign up_mode = g_st[k-1].mode_q;
        end

        // stage load from upstream on adv, hold otherwise
        always_comb begin
            dat_d  = dat_q;
            sh_d   = sh_q;
            dir_d  = dir_q;
            mode_d = mode_q;
            if (adv) begin
                dat_d  = up_dat;
                sh_d   = up_sh;
                dir_d  = up_dir;
                mode_d = up_mode;
            end
        end

        // stage payload registers, zeroed on reset
        always_ff @(posedge clk) begin
            if (rst) begin
                dat_q  <= '0;
                sh_q   <= '0;
                dir_q  <= 1'b0;
                mode_q <= 2'b00;
            end else begin
                dat_q  <= dat_d;
                sh_q   <= sh_d;
                dir_q  <= dir_d;
                mode_q <= mode_d;
            end
        end

        assign res = sh_q[0] ? shift_step(dat_q, 1 << k, dir_q, mode_q) : dat_q;
    end

    // zero data shifted by anything is zero, so a_out reads 0 after reset
    assign a_out = g_st[L-1].res;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb_pipelined_barrel_shifter: directed steps plus a randomized phase, with a
// bit-level reference model feeding an in-order scoreboard.
module tb_pipelined_barrel_shifter;
    localparam int W  = 16;
    localparam int SW = 4;
    localparam int L  = 4;

    logic          clk = 1'b0;
    logic          rst, in_valid, in_ready, dir, out_valid, out_ready;
    logic [W-1:0]  a_in, a_out;
    logic [SW-1:0] shamt;
    logic [1:0]    mode;

    int            n_assert = 0;
    int            n_fail   = 0;
    logic [W-1:0]  exp_q[$];

    always #5 clk = ~clk;

    pipelined_barrel_shifter #(.WIDTH(W), .SHAMT_WIDTH(SW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .shamt(shamt), .dir(dir), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready), .a_out(a_out)
    );

    // bit-by-bit reference: output bit i takes source bit i-s (left) or i+s (right)
    function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [SW-1:0] s,
                                           input logic d, input logic [1:0] m);
        logic [W-1:0] r;
        int src;
        for (int i = 0; i < W; i++) begin
            src = d ? i + int'(s) : i - int'(s);
            if (m == 2'b00)   r[i] = a[(src + W) % W];
            else if (src < 0) r[i] = 1'b0;
            else if (src >= W) r[i] = (m == 2'b10) ? a[W-1] : 1'b0;
            else              r[i] = a[src];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] e);
        n_assert++;
        assert (got === e) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, e);
        end
    endtask

    task automatic chkb(input string tag, input logic got, input logic e);
        n_assert++;
        assert (got === e) else begin
            n_fail++;
            $error("FAIL %s: got %b expected %b", tag, got, e);
        end
    endtask

    // wait up to maxw cycles for out_valid, check data, then step one cycle
    task automatic expect_out(input string tag, input logic [W-1:0] e, input int maxw);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < maxw) begin
            @(posedge clk); #2;
            n++;
        end
        n_assert++;
        assert (out_valid === 1'b1 && a_out === e) else begin
            n_fail++;
            $error("FAIL %s: out_valid=%b a_out=%h expected valid data %h", tag, out_valid, a_out, e);
        end
        @(posedge clk); #2;
    endtask

    // beat already on inputs at P+1; checks exact L-cycle latency
    task automatic send_and_time(input string tag, input logic [W-1:0] e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1;
        chkb({tag, "_lat1"}, out_valid, 1'b0);
        for (int i = 2; i <= L; i++) begin
            @(posedge clk); #2;
            chkb({tag, "_lat"}, out_valid, (i == L));
        end
        chk(tag, a_out, e);
        @(posedge clk); #1;
    endtask

    // scoreboard / stability checker, sampled on the falling edge
    initial begin
        logic [W-1:0] e;
        logic         prev_stall;
        logic [W-1:0] prev_dat;
        prev_stall = 1'b0;
        prev_dat   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    n_assert++;
                    assert (out_valid === 1'b1 && a_out === prev_dat) else begin
                        n_fail++;
                        $error("FAIL stall_stable: out_valid=%b a_out=%h expected 1/%h", out_valid, a_out, prev_dat);
                    end
                end
                if (out_valid && out_ready) begin
                    n_assert++;
                    assert (exp_q.size() > 0) else begin
                        n_fail++;
                        $error("FAIL unexpected_beat: got %h expected no beat", a_out);
                    end
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        n_assert++;
                        assert (a_out === e) else begin
                            n_fail++;
                            $error("FAIL sb_data: got %h expected %h", a_out, e);
                        end
                    end
                end
                if (in_valid && in_ready) exp_q.push_back(model(a_in, shamt, dir, mode));
                prev_stall = out_valid && !out_ready;
                prev_dat   = a_out;
            end
        end
    end

    initial begin
        int acc_cnt, cyc;
        bit acc;
        rst = 1'b1; in_valid = 1'b0; a_in = '0; shamt = '0; dir = 1'b0; mode = 2'b00;
        out_ready = 1'b1;
        @(posedge clk); #1;
        // beat presented while rst is high must never be accepted
        in_valid = 1'b1; a_in = 16'hFFFF; shamt = 4'd1;
        #1;
        chkb("rst_out_valid", out_valid, 1'b0);
        chkb("rst_in_ready", in_ready, 1'b1);
        chk("rst_a_out", a_out, 16'h0000);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1; chkb("post_rst_idle", out_valid, 1'b0);
            @(posedge clk); #1;
        end

        // rotate left by 1, latency
        a_in = 16'h8001; shamt = 4'd1; dir = 1'b0; mode = 2'b00; in_valid = 1'b1;
        send_and_time("rotl1", 16'h0003);

        // right by 15 in arithmetic / logical / reserved modes
        a_in = 16'h8000; shamt = 4'd15; dir = 1'b1; in_valid = 1'b1;
        mode = 2'b10; @(posedge clk); #1;
        mode = 2'b01; @(posedge clk); #1;
        mode = 2'b11; @(posedge clk); #1;
        in_valid = 1'b0; #1;
        expect_out("asr15", 16'hFFFF, 8);
        expect_out("lsr15", 16'h0001, 0);
        expect_out("rsv15", 16'h0001, 0);

        // four back-to-back beats, consecutive outputs
        shamt = 4'd4; dir = 1'b0; mode = 2'b00; in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            a_in = 16'(i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        expect_out("rot4_b1", 16'h0010, 8);
        expect_out("rot4_b2", 16'h0020, 0);
        expect_out("rot4_b3", 16'h0030, 0);
        expect_out("rot4_b4", 16'h0040, 0);

        // fill with downstream stalled
        out_ready = 1'b0; in_valid = 1'b1;
        a_in = 16'h1234; shamt = 4'd4; dir = 1'b0; mode = 2'b00;
        #1; chkb("fill_rdy", in_ready, 1'b1); @(posedge clk); #1;
        a_in = 16'h1234; shamt = 4'd4; dir = 1'b1; mode = 2'b00;
        #1; chkb("fill_rdy", in_ready, 1'b1); @(posedge clk); #1;
        a_in = 16'hF0F0; shamt = 4'd8; dir = 1'b1; mode = 2'b10;
        #1; chkb("fill_rdy", in_ready, 1'b1); @(posedge clk); #1;
        a_in = 16'hF0F0; shamt = 4'd3; dir = 1'b0; mode = 2'b01;
        #1; chkb("fill_rdy", in_ready, 1'b1); @(posedge clk); #1;
        a_in = 16'h5555; shamt = 4'd0; dir = 1'b1; mode = 2'b10;
        for (int i = 0; i < 10; i++) begin
            #1;
            chkb("stall_rdy", in_ready, 1'b0);
            chkb("stall_vld", out_valid, 1'b1);
            chk("stall_data", a_out, 16'h2341);
            @(posedge clk); #1;
        end
        out_ready = 1'b1; #1;
        chkb("drain_rdy", in_ready, 1'b1);
        chk("drain_b1", a_out, 16'h2341);
        @(posedge clk); #1;
        in_valid = 1'b0; #1;
        expect_out("drain_b2", 16'h4123, 0);
        expect_out("drain_b3", 16'hFFF0, 0);
        expect_out("drain_b4", 16'h8780, 0);
        expect_out("drain_b5", 16'h5555, 0);

        // reset with three beats in flight
        in_valid = 1'b1; shamt = 4'd1; dir = 1'b0; mode = 2'b01;
        a_in = 16'hAAAA; @(posedge clk); #1;
        a_in = 16'hBBBB; @(posedge clk); #1;
        a_in = 16'hCCCC; @(posedge clk); #1;
        in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; #1;
        chkb("flush_vld", out_valid, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #2;
            chkb("flush_idle", out_valid, 1'b0);
        end
        a_in = 16'h00F0; shamt = 4'd2; dir = 1'b1; mode = 2'b01; in_valid = 1'b1;
        send_and_time("post_flush", 16'h003C);

        // randomized traffic against the scoreboard
        acc_cnt = 0; cyc = 0; in_valid = 1'b0;
        while (acc_cnt < 1000 && cyc < 20000) begin
            out_ready = ($urandom_range(0, 9) < 7);
            if (!in_valid && $urandom_range(0, 9) < 7) begin
                in_valid = 1'b1;
                a_in     = 16'($urandom);
                shamt    = 4'($urandom_range(0, 15));
                dir      = 1'($urandom_range(0, 1));
                mode     = 2'($urandom_range(0, 3));
            end
            #1;
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                acc_cnt++;
                in_valid = 1'b0;
            end
        end
        n_assert++;
        assert (acc_cnt == 1000) else begin
            n_fail++;
            $error("FAIL rand_accept: got %0d beats expected 1000", acc_cnt);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        n_assert++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL rand_drain: got %0d beats outstanding expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pipelined_barrel_shifter.md
PIPELINED_BARREL_SHIFTER -- requirements
Module: pipelined_barrel_shifter

Interface
REQ-001 Parameter WIDTH, default 16, data width; SHALL be a power of two, minimum 4.
REQ-002 Parameter SHAMT_WIDTH, default $clog2(WIDTH), shift-amount width and pipeline depth L.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  input beat present.
REQ-006 in_ready  output  1  block can accept a beat this cycle.
REQ-007 a_in  input  WIDTH  operand.
REQ-008 shamt  input  SHAMT_WIDTH  shift/rotate amount, 0..WIDTH-1.
REQ-009 dir  input  1  0 = left, 1 = right.
REQ-010 mode  input  2  00 = rotate, 01 = logical shift, 10 = arithmetic shift, 11 = reserved.
REQ-011 out_valid  output  1  result beat present.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 a_out  output  WIDTH  result.

Function
REQ-014 Pipeline SHALL have exactly L = SHAMT_WIDTH register stages; stage k applies a shift of 2^k when shamt bit k is 1, LSB first.
REQ-015 Each stage SHALL carry data, remaining shamt bits, dir, mode, and a valid bit.
REQ-016 Global advance enable: adv = !out_valid || out_ready; all stages load together when adv = 1 and hold when adv = 0.
REQ-017 in_ready SHALL equal adv, combinationally; a beat is accepted when in_valid && in_ready.
REQ-018 Stage 0 valid SHALL load in_valid && in_ready when adv = 1; bubbles propagate as invalid stages.
REQ-019 Latency SHALL be L cycles from acceptance to out_valid with no stall; throughput one beat per cycle.
REQ-020 Beats SHALL emerge in acceptance order; no beat is dropped or duplicated.
REQ-021 While out_valid && !out_ready, a_out and out_valid SHALL remain stable.
REQ-022 Rotate: left = (a << s) | (a >> (WIDTH-s)); right = (a >> s) | (a << (WIDTH-s)); s = 0 passes a unchanged.
REQ-023 Logical shift: zero fill in the vacated bits, both directions.
REQ-024 Arithmetic: right fills with a[WIDTH-1]; left is identical to logical left.
REQ-025 Mode 11 SHALL behave as mode 01.
REQ-026 shamt = 0 SHALL pass a_in unchanged for every mode and dir.
REQ-027 Arithmetic right by WIDTH-1 SHALL yield all copies of the sign bit.

Reset
REQ-028 While rst = 1, all stage valid bits SHALL clear at the clock edge; out_valid = 0 and in_ready = 1 from the next cycle.
REQ-029 a_out and stage data SHALL reset to 0.
REQ-030 Reset mid-operation SHALL discard all in-flight beats; the first beat accepted after reset deasserts emerges L cycles later.
REQ-031 A beat presented in the same cycle as rst = 1 SHALL NOT be accepted.

Verification (WIDTH = 16, L = 4)
REQ-032 a_in=16'h8001, shamt=1, dir=0, mode=00, out_ready=1 -> a_out=16'h0003, out_valid 4 cycles after acceptance.
REQ-033 a_in=16'h8000, shamt=15, dir=1: mode=10 -> 16'hFFFF; mode=01 -> 16'h0001; mode=11 -> 16'h0001.
REQ-034 Four back-to-back beats 16'h0001..16'h0004, shamt=4, dir=0, mode=00 -> outputs 16'h0010, 16'h0020, 16'h0030, 16'h0040 on consecutive cycles.
REQ-035 Fill the pipeline with out_ready=0 -> in_ready=0 and a_out stable across 10 cycles; raise out_ready -> all beats drain in order with no loss.
REQ-036 Assert rst for 1 cycle with 3 beats in flight -> out_valid=0 the next cycle; no stale beat ever appears.
REQ-037 Random run of 1000 beats with random in_valid and out_ready -> each result matches a scoreboard model built from REQ-022 to REQ-025, in order.
